// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: opcodes, FSM states and framing constants for the SPI flash responder
package spi_flash_pkg;
  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_PP   = 8'h02;
  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_WRDI = 8'h04;
  localparam logic [7:0] CMD_RDSR = 8'h05;
  localparam int ADDR_BYTES = 3;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, RDATA, STATUS, PDATA, IGNORE} state_t;
endpackage

// File: rtl/spi_flash_responder_if.sv
// spi_flash_responder_if: SPI bus between controller (master) and flash responder (slave); SCK/CS/MOSI in, MISO/OE out
interface spi_flash_responder_if;
  logic i_SPI_CLK;
  logic i_SPI_CS;
  logic i_SPI_MOSI;
  logic o_SPI_MISO;
  logic o_miso_oe;
  modport master (output i_SPI_CLK, i_SPI_CS, i_SPI_MOSI, input o_SPI_MISO, o_miso_oe);
  modport slave (input i_SPI_CLK, i_SPI_CS, i_SPI_MOSI, output o_SPI_MISO, o_miso_oe);
endinterface

// File: rtl/spi_slave_sync_edge.sv
// spi_slave_sync_edge: 2-flop sync of SCK/CS/MOSI plus SCK and CS edge pulses (clk, reset active-low async)
module spi_slave_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic sck,
  input  logic cs,
  input  logic mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_rise,
  output logic cs_fall,
  output logic cs_sync,
  output logic mosi_sync
);
  // bit 2 is the previous synchronised value, used only for edge detection
  logic [2:0] sck_p, cs_p;
  logic [1:0] mosi_p;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_p  <= '0;
      cs_p   <= '1;
      mosi_p <= '0;
    end else begin
      sck_p  <= {sck_p[1:0], sck};
      cs_p   <= {cs_p[1:0], cs};
      mosi_p <= {mosi_p[0], mosi};
    end
  end
  assign sck_rise  = sck_p[1] & ~sck_p[2];
  assign sck_fall  = ~sck_p[1] & sck_p[2];
  assign cs_rise   = cs_p[1] & ~cs_p[2];
  assign cs_fall   = ~cs_p[1] & cs_p[2];
  assign cs_sync   = cs_p[1];
  assign mosi_sync = mosi_p[1];
endmodule

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 NOR flash stand-in; ports clk, reset (async low), spi bus, backdoor we/addr/wdata/rdata, o_wel, o_prog_strobe
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int         ADDR_W    = 12,
  parameter logic [7:0] STATUS_ID = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  spi_flash_responder_if.slave  spi,
  input  logic                  i_bd_we,
  input  logic [ADDR_W-1:0]     i_bd_addr,
  input  logic [7:0]            i_bd_wdata,
  output logic [7:0]            o_bd_rdata,
  output logic                  o_wel,
  output logic                  o_prog_strobe
);
  state_t state, state_d;
  logic sck_rise, sck_fall, cs_rise, cs_fall, cs_s, mosi;
  logic [2:0] bit_cnt, tx_cnt;
  logic [1:0] addr_cnt;
  logic [7:0] rx_sr, miso_sr, rx_byte, status;
  logic miso_bit, is_read, committed, wel, byte_done, addr_last, commit, tx_phase;
  logic [ADDR_W-1:0] addr, addr_shift, addr_inc;
  logic [7:0] mem [0:(1<<ADDR_W)-1];

  spi_slave_sync_edge u_sync (
    .clk, .reset,
    .sck(spi.i_SPI_CLK), .cs(spi.i_SPI_CS), .mosi(spi.i_SPI_MOSI),
    .sck_rise, .sck_fall, .cs_rise, .cs_fall, .cs_sync(cs_s), .mosi_sync(mosi)
  );

  assign rx_byte    = {rx_sr[6:0], mosi};
  assign byte_done  = sck_rise & ~cs_s & (bit_cnt == 3'd7);
  assign addr_shift = {addr[ADDR_W-2:0], mosi};
  assign addr_inc   = addr + ADDR_W'(1);
  assign addr_last  = byte_done & (addr_cnt == 2'(ADDR_BYTES-1));
  assign status     = {STATUS_ID[7:2], wel, 1'b0};
  assign commit     = (state == PDATA) & byte_done;
  assign tx_phase   = (state == RDATA) | (state == STATUS);

  assign spi.o_miso_oe  = tx_phase & ~cs_s;
  assign spi.o_SPI_MISO = spi.o_miso_oe & miso_bit;
  assign o_wel          = wel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (cs_s)
      state_d = IDLE;
    else if (state == IDLE && cs_fall)
      state_d = CMD;
    else if (state == CMD && byte_done)
      state_d = (rx_byte == CMD_READ)         ? ADDR :
                (rx_byte == CMD_PP && wel)    ? ADDR :
                (rx_byte == CMD_RDSR)         ? STATUS : IGNORE;
    else if (state == ADDR && addr_last)
      state_d = is_read ? RDATA : PDATA;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt       <= '0;
      tx_cnt        <= '0;
      addr_cnt      <= '0;
      rx_sr         <= '0;
      miso_sr       <= '0;
      miso_bit      <= 1'b0;
      addr          <= '0;
      is_read       <= 1'b0;
      committed     <= 1'b0;
      wel           <= 1'b0;
      o_prog_strobe <= 1'b0;
      o_bd_rdata    <= '0;
    end else begin
      o_prog_strobe <= commit;
      o_bd_rdata    <= mem[i_bd_addr];
      // a PP that programmed at least one byte consumes the write enable
      if (cs_rise && state == PDATA && committed) wel <= 1'b0;
      if (cs_s) begin
        bit_cnt   <= '0;
        tx_cnt    <= '0;
        addr_cnt  <= '0;
        miso_bit  <= 1'b0;
        committed <= 1'b0;
      end else begin
        if (sck_rise) begin
          rx_sr   <= rx_byte;
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (state == CMD && byte_done) begin
          wel      <= (rx_byte == CMD_WREN) ? 1'b1 : (rx_byte == CMD_WRDI) ? 1'b0 : wel;
          is_read  <= rx_byte == CMD_READ;
          miso_sr  <= status;
          tx_cnt   <= '0;
          addr_cnt <= '0;
        end
        // the address shifts in whole; after 24 bits only the low ADDR_W remain
        if (state == ADDR && sck_rise) begin
          addr     <= addr_shift;
          addr_cnt <= byte_done ? addr_cnt + 2'd1 : addr_cnt;
          if (addr_last) miso_sr <= mem[addr_shift];
        end
        if (tx_phase && sck_fall) begin
          miso_bit <= miso_sr[7];
          tx_cnt   <= tx_cnt + 3'd1;
          if (tx_cnt == 3'd7) begin
            miso_sr <= (state == STATUS) ? status : mem[addr_inc];
            if (state == RDATA) addr <= addr_inc;
          end else
            miso_sr <= {miso_sr[6:0], 1'b0};
        end
        // page program wraps inside the 256-byte page
        if (commit) begin
          committed <= 1'b1;
          addr      <= {addr[ADDR_W-1:8], addr[7:0] + 8'd1};
        end
      end
    end
  end

  // backdoor write is ordered last so it wins over a same-address commit
  always_ff @(posedge clk) begin
    if (commit)  mem[addr] <= mem[addr] & rx_byte;
    if (i_bd_we) mem[i_bd_addr] <= i_bd_wdata;
  end
endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: scoreboard bench driving SPI mode-0 transactions and backdoor reads
module tb_spi_flash_responder;
  import spi_flash_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic bd_we = 1'b0;
  logic [11:0] bd_addr = '0;
  logic [7:0] bd_wdata = '0, bd_rdata;
  logic wel, prog_strobe;
  int compared = 0, mismatched = 0, strobes = 0, bad_miso = 0, oe_hi = 0;
  string tag_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx;
  int s0;

  spi_flash_responder_if spi();

  spi_flash_responder #(.ADDR_W(12), .STATUS_ID(8'h00)) dut (
    .clk(clk), .reset(reset), .spi(spi.slave),
    .i_bd_we(bd_we), .i_bd_addr(bd_addr), .i_bd_wdata(bd_wdata), .o_bd_rdata(bd_rdata),
    .o_wel(wel), .o_prog_strobe(prog_strobe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (prog_strobe) strobes++;
  always @(negedge clk) if (!spi.o_miso_oe && spi.o_SPI_MISO) bad_miso++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic score(input logic [7:0] got);
    check("sb_nonempty", 32'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) check(tag_q.pop_front(), got, exp_q.pop_front());
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] r);
    r = '0;
    for (int i = 0; i < n; i++) begin
      spi.i_SPI_MOSI = tx[7-i];
      idle(5);
      spi.i_SPI_CLK = 1'b1;
      r = {r[6:0], spi.o_SPI_MISO};
      if (spi.o_miso_oe) oe_hi++;
      idle(5);
      spi.i_SPI_CLK = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] r);
    spi_bits(tx, 8, r);
  endtask

  task automatic cs_low;
    @(negedge clk);
    spi.i_SPI_CS = 1'b0;
    idle(5);
  endtask

  task automatic cs_high;
    idle(5);
    spi.i_SPI_CS = 1'b1;
    idle(8);
  endtask

  task automatic cmd1(input logic [7:0] op);
    logic [7:0] r;
    cs_low;
    xfer(op, r);
    cs_high;
  endtask

  task automatic cmd4(input logic [7:0] op, input logic [23:0] a);
    logic [7:0] r;
    xfer(op, r);
    xfer(a[23:16], r);
    xfer(a[15:8], r);
    xfer(a[7:0], r);
  endtask

  task automatic bd_write(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_wdata = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic bd_check(input string tag, input logic [11:0] a, input logic [7:0] exp);
    expect_byte(tag, exp);
    @(negedge clk);
    bd_addr = a;
    @(negedge clk);
    score(bd_rdata);
  endtask

  initial begin
    spi.i_SPI_CLK = 1'b0;
    spi.i_SPI_CS = 1'b1;
    spi.i_SPI_MOSI = 1'b0;
    idle(3);
    check("rst_oe", spi.o_miso_oe, 0);
    check("rst_miso", spi.o_SPI_MISO, 0);
    check("rst_wel", wel, 0);
    check("rst_strobe", prog_strobe, 0);
    check("rst_bdrdata", bd_rdata, 0);
    reset = 1'b1;
    idle(4);

    // basic READ across two consecutive bytes
    bd_write(12'hAAA, 8'hFA);
    bd_write(12'hAAB, 8'h5C);
    cs_low;
    oe_hi = 0;
    cmd4(CMD_READ, 24'h003AAA);
    check("read_oe_cmd", oe_hi, 0);
    expect_byte("read_b0", 8'hFA);
    expect_byte("read_b1", 8'h5C);
    oe_hi = 0;
    xfer(8'h00, rx); score(rx);
    xfer(8'h00, rx); score(rx);
    check("read_oe_data", oe_hi, 16);
    cs_high;
    check("read_oe_after", spi.o_miso_oe, 0);

    // page program with WREN, then a second program ANDs into the byte
    bd_write(12'h000, 8'hFF);
    cmd1(CMD_WREN);
    check("wren_wel", wel, 1);
    s0 = strobes;
    cs_low; cmd4(CMD_PP, 24'h003000); xfer(8'hAA, rx); cs_high;
    check("pp1_strobes", strobes - s0, 1);
    check("pp1_wel", wel, 0);
    bd_check("pp1_mem", 12'h000, 8'hAA);
    cmd1(CMD_WREN);
    cs_low; cmd4(CMD_PP, 24'h003000); xfer(8'h0F, rx); cs_high;
    bd_check("pp2_mem", 12'h000, 8'h0A);

    // PP without WREN is ignored
    s0 = strobes;
    cs_low; cmd4(CMD_PP, 24'h000000); xfer(8'h00, rx); cs_high;
    check("ppnw_strobes", strobes - s0, 0);
    bd_check("ppnw_mem", 12'h000, 8'h0A);

    // status register reflects WEL and repeats
    cmd1(CMD_WREN);
    cs_low; xfer(CMD_RDSR, rx);
    for (int i = 0; i < 3; i++) begin
      expect_byte("rdsr_wel1", 8'h02);
      xfer(8'h00, rx); score(rx);
    end
    cs_high;
    cmd1(CMD_WRDI);
    check("wrdi_wel", wel, 0);
    cs_low; xfer(CMD_RDSR, rx);
    expect_byte("rdsr_wel0", 8'h00);
    xfer(8'h00, rx); score(rx);
    cs_high;

    // PP wraps inside the 256-byte page
    bd_write(12'h0FE, 8'hFF); bd_write(12'h0FF, 8'hFF);
    bd_write(12'h100, 8'hFF); bd_write(12'h101, 8'hFF);
    bd_write(12'h000, 8'hFF); bd_write(12'h001, 8'hFF);
    cmd1(CMD_WREN);
    s0 = strobes;
    cs_low; cmd4(CMD_PP, 24'h0000FE);
    xfer(8'h11, rx); xfer(8'h22, rx); xfer(8'h33, rx); xfer(8'h44, rx);
    cs_high;
    check("wrap_strobes", strobes - s0, 4);
    check("wrap_wel", wel, 0);
    bd_check("wrap_0fe", 12'h0FE, 8'h11);
    bd_check("wrap_0ff", 12'h0FF, 8'h22);
    bd_check("wrap_000", 12'h000, 8'h33);
    bd_check("wrap_001", 12'h001, 8'h44);
    bd_check("wrap_100", 12'h100, 8'hFF);
    bd_check("wrap_101", 12'h101, 8'hFF);

    // abort after 5 address bits, then a normal READ
    cs_low; xfer(CMD_READ, rx); spi_bits(8'h00, 5, rx); cs_high;
    check("abort_idle", 32'(dut.state), 32'(IDLE));
    cs_low; cmd4(CMD_READ, 24'h000AAA);
    expect_byte("abort_read0", 8'hFA);
    expect_byte("abort_read1", 8'h5C);
    xfer(8'h00, rx); score(rx);
    xfer(8'h00, rx); score(rx);
    cs_high;

    // async reset in the middle of a data-out phase
    cmd1(CMD_WREN);
    cs_low; cmd4(CMD_READ, 24'h000AAA); spi_bits(8'h00, 4, rx);
    check("pre_rst_oe", spi.o_miso_oe, 1);
    check("pre_rst_wel", wel, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_oe", spi.o_miso_oe, 0);
    check("mid_rst_wel", wel, 0);
    spi.i_SPI_CLK = 1'b0;
    spi.i_SPI_CS = 1'b1;
    idle(3);
    reset = 1'b1;
    idle(4);
    check("miso_zero_when_off", bad_miso, 0);
    check("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
